// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type, port indices and default burst length for the refill arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BURST, RELEASE} state_t;
  localparam int PORT_I = 0;
  localparam int PORT_D = 1;
  localparam int BURST_LEN_DEF = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; the port that was not granted last wins a tie.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic [1:0] win
);
  assign win[PORT_I] = req[PORT_I] & (~req[PORT_D] | rr_last);
  assign win[PORT_D] = req[PORT_D] & (~req[PORT_I] | ~rr_last);
endmodule

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares the memory refill port between the I- and D-cache controllers,
// granting whole bursts in round-robin order and forwarding beats to the granted port only.
module mem_burst_arbiter import mem_arb_pkg::*; #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_cc2arb,
  input  logic [2*ADR_WIDTH-1:0] adr_cc2arb,
  output logic [1:0]             ack_arb2cc,
  output logic [DATA_WIDTH-1:0]  dat_arb2cc,
  output logic                   req_arb2mem,
  output logic [ADR_WIDTH-1:0]   adr_arb2mem,
  input  logic                   ack_mem2arb,
  input  logic [DATA_WIDTH-1:0]  dat_mem2arb,
  output logic [1:0]             gnt_arb,
  output logic                   err_spur
);
  localparam int CW = $clog2(BURST_LEN);
  state_t        state;
  logic          rr_last;
  logic [CW-1:0] beat_cnt;
  logic [1:0]    win;
  logic          own_req, last;
  rr_arb2 u_rr (.req(req_cc2arb), .rr_last(rr_last), .win(win));
  assign own_req = req_cc2arb[gnt_arb[PORT_D]];
  assign last    = beat_cnt == CW'(BURST_LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= 1'b1;
      beat_cnt    <= '0;
      gnt_arb     <= '0;
      req_arb2mem <= 1'b0;
      adr_arb2mem <= '0;
      ack_arb2cc  <= '0;
      dat_arb2cc  <= '0;
      err_spur    <= 1'b0;
    end else begin
      ack_arb2cc <= '0;
      if (ack_mem2arb && state != BURST) err_spur <= 1'b1;
      case (state)
        IDLE: if (|req_cc2arb) begin
          gnt_arb     <= win;
          rr_last     <= win[PORT_D];
          adr_arb2mem <= win[PORT_D] ? adr_cc2arb[ADR_WIDTH +: ADR_WIDTH] : adr_cc2arb[0 +: ADR_WIDTH];
          req_arb2mem <= 1'b1;
          beat_cnt    <= '0;
          state       <= BURST;
        end
        // the last beat is forwarded even if the requester drops in the same cycle
        BURST: if (ack_mem2arb && (own_req || last)) begin
          ack_arb2cc <= gnt_arb;
          dat_arb2cc <= dat_mem2arb;
          beat_cnt   <= beat_cnt + CW'(1);
          if (last) begin
            req_arb2mem <= 1'b0;
            gnt_arb     <= '0;
            state       <= RELEASE;
          end
        end else if (!own_req) begin
          req_arb2mem <= 1'b0;
          gnt_arb     <= '0;
          state       <= RELEASE;
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
